hidden_sampler_buf: RTL
=======================

// Module: hidden_sampler_buf
// PURPOSE
//  Stage between rbm_core_min (one p_j per hidden unit, Q0.16) and outerprod_accum (h_p[H_TILE] vector).
//  Draws a Bernoulli sample per hidden unit from an internal 16-bit LFSR and collects one tile of
//  H_TILE values into a ping-pong buffer. Presents a complete tile as a parallel vector with a
//  valid/ready handshake. Mode selects the tile contents: raw probability (pos-phase stats) or
//  binary sample (Gibbs step).
// PARAMETERS
//  H_TILE  64  hidden units per tile; power of two, 2..256
//  CNT_W   $clog2(H_TILE+1)  width of count outputs
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous, active-high reset
//  seed       in   16        LFSR seed; loaded on rst or seed_load
//  seed_load  in   1         reload LFSR from seed; other state is unaffected
//  mode       in   1         0 = out_h carries p; 1 = out_h carries sample (16'hFFFF / 16'h0000)
//  in_valid   in   1         in_p valid
//  in_ready   out  1         stage can accept in_p
//  in_p       in   16        hidden probability, Q0.16 unsigned
//  in_last    in   1         last hidden of the current tile (short tile allowed)
//  out_valid  out  1         a full tile is presented
//  out_ready  in   1         consumer takes the tile
//  out_h      out  16xH_TILE tile vector, Q0.16; unused entries read 0
//  out_s      out  H_TILE    sampled bits for the tile; unused bits read 0
//  out_cnt    out  CNT_W     number of valid entries in the tile (1..H_TILE)
//  out_ones   out  CNT_W     popcount of out_s
// BEHAVIOUR
//  Reset: out_valid=0, out_cnt=0, out_ones=0, out_h/out_s all 0, both banks empty, wr_bank=rd_bank=0,
//   wr_ptr=0, in_ready=1 from the first cycle after reset, LFSR<=seed (16'h0001 if seed==0).
//  LFSR: Fibonacci, next={s[14:0], s[15]^s[13]^s[12]^s[10]}, same polynomial as lfsr16. Steps only on an
//   accepted input. seed_load has priority over the step in the same cycle.
//  Sample: s=(rnd <= in_p) unsigned, using the LFSR state before the step. rnd is never 0, so
//   p=0 gives 0 and p=16'hFFFF gives 1.
//  Accept: accept = in_valid & in_ready. On accept:
//   - bank[wr_bank][wr_ptr] <= (mode ? {16{s}} : in_p); sbit <= s;
//   - wr_ptr++.
//   - mode is sampled per input, not per tile.
//  Tile close: on accept with wr_ptr==H_TILE-1 or in_last:
//   - full[wr_bank]<=1; cnt[wr_bank]<=wr_ptr+1; wr_ptr<=0; wr_bank toggles.
//   - Short tile: entries above cnt are zeroed in the same cycle (bank write, all entries).
//  in_ready = !full[wr_bank] (combinational from registers). Both banks full -> 0.
//  Output:
//   - out_valid = full[rd_bank]. out_h/out_s/out_cnt/out_ones are driven from bank rd_bank, registered.
//   - out_ones is computed when the tile closes and stored per bank.
//   - On out_valid & out_ready: full[rd_bank]<=0, rd_bank toggles.
//  Latency: the tile closes on the accept in cycle t; out_valid=1 in cycle t+1 if that bank is rd_bank.
//  Throughput: 1 input/cycle sustained while the consumer drains one tile per <=H_TILE cycles.
//  Simultaneous events:
//   - Tile close into bank A and drain of bank B in the same cycle: both apply.
//   - If only one bank was full and it drains while the other closes, out_valid stays 1 (next tile).
//   - Closing into a bank is impossible while that bank is full (in_ready=0).
//  Outputs are stable while out_valid=1 and !out_ready. in_p/in_last are ignored when !accept.
//  rst mid-tile: partial tile and both full banks are discarded; no out_valid pulse.
// STRUCTURE
//  rbm_pkg (shared): typedef q0_16_t=logic[15:0]; q1_7_t=logic signed[7:0]; q1_15_t=logic signed[15:0];
//   LFSR_TAPS constant; function lfsr_next(q0_16_t).
//  Sub-module hsb_bank: one tile buffer with write port, zero-fill-above-count, stored cnt/ones, full flag;
//   instantiated twice. LFSR is inline via rbm_pkg::lfsr_next (lfsr16 has no enable).
// TESTING
//  1 H_TILE=4, mode=0, seed=16'hACE1, p=1000,2000,3000,4000 back-to-back, out_ready=1 -> out_valid 1 cycle
//    after 4th accept; out_h={1000,2000,3000,4000}, out_cnt=4; out_s equals a reference model of the LFSR.
//  2 mode=1, p=0 x4 then p=16'hFFFF x4 -> tile0 out_s=4'b0000, out_ones=0, out_h all 0;
//    tile1 out_s=4'b1111, out_ones=4, out_h all 16'hFFFF.
//  3 out_ready=0, stream 12 inputs -> in_ready drops after the 8th accept; out_valid held with tile0 stable;
//    release out_ready -> tile0 then tile1 delivered in order, no value lost or duplicated.
//  4 in_last on 2nd input (H_TILE=4, p=500,600) -> out_cnt=2, out_h={500,600,0,0}, upper out_s bits 0;
//    next tile starts at entry 0.
//  5 rst asserted after 3 accepts with one bank full -> next cycle out_valid=0, in_ready=1; 4 new inputs
//    form a clean tile; LFSR restarts from seed (sample sequence matches test 1).
//  6 seed=0 -> LFSR runs from 16'h0001, never reaches 0; with p=16'hFFFF x1000, every out_s bit is 1.

Source files
------------

// File: rtl/rbm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rbm_pkg
// Description : Shared RBM datapath types and the 16-bit Fibonacci LFSR step
//               (x^16 + x^14 + x^13 + x^11 + 1, same polynomial as lfsr16).
// Contents    : q0_16_t, q1_7_t, q1_15_t, LFSR_TAPS, lfsr_next()
// Revision    : 1.0 - initial release
// ============================================================================
package rbm_pkg;

  typedef logic        [15:0] q0_16_t;
  typedef logic signed [7:0]  q1_7_t;
  typedef logic signed [15:0] q1_15_t;

  // Feedback taps on state bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Shift left, feedback XOR enters at bit 0. The all-zero state is a fixed
  // point, so callers must never seed with zero.
  function automatic q0_16_t lfsr_next(input q0_16_t s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hsb_bank.sv
`default_nettype none
// ============================================================================
// Module      : hsb_bank
// Description : One tile buffer of the hidden sampler ping-pong pair. Holds
//               H_TILE probability/sample entries, the tile count, the
//               popcount of the sample bits and a full flag.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               wr_en_i       - write wr_data_i/wr_bit_i at wr_ptr_i
//               close_i       - tile closes this cycle (with the write)
//               clr_i         - consumer took the tile; release the bank
//               wr_ptr_i      - entry index of the current write
//               wr_data_i     - Q0.16 entry value
//               wr_bit_i      - sampled bit for the entry
//               full_o        - bank holds a complete tile
//               h_o, s_o      - stored entries / sample bits
//               cnt_o, ones_o - stored entry count / popcount of s_o
// Revision    : 1.0 - initial release
// ============================================================================
module hsb_bank
  import rbm_pkg::*;
#(
  parameter int H_TILE = 64,
  parameter int CNT_W  = $clog2(H_TILE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic                      close_i,
  input  logic                      clr_i,
  input  logic [$clog2(H_TILE)-1:0] wr_ptr_i,
  input  q0_16_t                    wr_data_i,
  input  logic                      wr_bit_i,
  output logic                      full_o,
  output logic [H_TILE-1:0][15:0]   h_o,
  output logic [H_TILE-1:0]         s_o,
  output logic [CNT_W-1:0]          cnt_o,
  output logic [CNT_W-1:0]          ones_o
);

  logic [H_TILE-1:0][15:0] data_q, data_d;
  logic [H_TILE-1:0]       bits_q, bits_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        ones_q, ones_d;
  logic                    full_q, full_d;

  always_comb begin
    data_d = data_q;
    bits_d = bits_q;
    cnt_d  = cnt_q;
    ones_d = ones_q;
    full_d = full_q;

    if (wr_en_i) begin
      data_d[wr_ptr_i] = wr_data_i;
      bits_d[wr_ptr_i] = wr_bit_i;
    end

    if (close_i) begin
      // Entries above the closing write may hold a previous tile; clear them
      // so a short tile reads zero in its unused slots.
      for (int i = 0; i < H_TILE; i++) begin
        if (i > int'(wr_ptr_i)) begin
          data_d[i] = '0;
          bits_d[i] = 1'b0;
        end
      end
      cnt_d  = CNT_W'(wr_ptr_i) + CNT_W'(1);
      ones_d = '0;
      for (int i = 0; i < H_TILE; i++) begin
        ones_d = ones_d + CNT_W'(bits_d[i]);
      end
      full_d = 1'b1;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      bits_q <= '0;
      cnt_q  <= '0;
      ones_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
      full_q <= full_d;
    end
  end

  assign full_o = full_q;
  assign h_o    = data_q;
  assign s_o    = bits_q;
  assign cnt_o  = cnt_q;
  assign ones_o = ones_q;

endmodule
`default_nettype wire

// File: rtl/hidden_sampler_buf.sv
`default_nettype none
// ============================================================================
// Module      : hidden_sampler_buf
// Description : Bernoulli-samples each incoming hidden probability against a
//               16-bit LFSR and gathers one tile of H_TILE results into a
//               ping-pong buffer, presented as a parallel vector with a
//               valid/ready handshake.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               seed_i, seed_load_i - LFSR seed and reload strobe
//               mode_i              - 0: store p, 1: store sample (FFFF/0000)
//               in_valid_i/in_ready_o, in_p_i, in_last_i - input stream
//               out_valid_o/out_ready_i - tile handshake
//               out_h_o, out_s_o    - tile entries / sample bits
//               out_cnt_o, out_ones_o - valid entries / popcount of out_s_o
// Revision    : 1.0 - initial release
// ============================================================================
module hidden_sampler_buf
  import rbm_pkg::*;
#(
  parameter int H_TILE = 64,
  parameter int CNT_W  = $clog2(H_TILE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  q0_16_t                  seed_i,
  input  logic                    seed_load_i,
  input  logic                    mode_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  q0_16_t                  in_p_i,
  input  logic                    in_last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [H_TILE-1:0][15:0] out_h_o,
  output logic [H_TILE-1:0]       out_s_o,
  output logic [CNT_W-1:0]        out_cnt_o,
  output logic [CNT_W-1:0]        out_ones_o
);

  localparam int PTR_W = $clog2(H_TILE);

  q0_16_t             lfsr_q, lfsr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;

  q0_16_t             seed_fix;
  logic               accept;
  logic               close;
  logic               drain;
  logic               samp;
  q0_16_t             wr_data;

  logic [1:0]              bank_full;
  logic [H_TILE-1:0][15:0] bank_h    [2];
  logic [H_TILE-1:0]       bank_s    [2];
  logic [CNT_W-1:0]        bank_cnt  [2];
  logic [CNT_W-1:0]        bank_ones [2];

  // A zero seed would lock the LFSR at zero.
  assign seed_fix = (seed_i == '0) ? 16'h0001 : seed_i;

  assign in_ready_o  = ~bank_full[wr_bank_q];
  assign out_valid_o = bank_full[rd_bank_q];

  assign accept  = in_valid_i & in_ready_o;
  assign close   = accept & ((wr_ptr_q == PTR_W'(H_TILE - 1)) | in_last_i);
  assign drain   = out_valid_o & out_ready_i;
  // LFSR state is never zero, so p=0 always samples 0 and p=FFFF always 1.
  assign samp    = (lfsr_q <= in_p_i);
  assign wr_data = mode_i ? {16{samp}} : in_p_i;

  always_comb begin
    lfsr_d    = lfsr_q;
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;

    if (seed_load_i) begin
      lfsr_d = seed_fix;
    end else if (accept) begin
      lfsr_d = lfsr_next(lfsr_q);
    end

    if (close) begin
      wr_ptr_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (drain) begin
      rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= seed_fix;
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    hsb_bank #(
      .H_TILE (H_TILE),
      .CNT_W  (CNT_W)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (accept & (wr_bank_q == 1'(b))),
      .close_i   (close  & (wr_bank_q == 1'(b))),
      .clr_i     (drain  & (rd_bank_q == 1'(b))),
      .wr_ptr_i  (wr_ptr_q),
      .wr_data_i (wr_data),
      .wr_bit_i  (samp),
      .full_o    (bank_full[b]),
      .h_o       (bank_h[b]),
      .s_o       (bank_s[b]),
      .cnt_o     (bank_cnt[b]),
      .ones_o    (bank_ones[b])
    );
  end

  // Outputs read zero whenever no tile is presented.
  assign out_h_o    = out_valid_o ? bank_h[rd_bank_q]    : '0;
  assign out_s_o    = out_valid_o ? bank_s[rd_bank_q]    : '0;
  assign out_cnt_o  = out_valid_o ? bank_cnt[rd_bank_q]  : '0;
  assign out_ones_o = out_valid_o ? bank_ones[rd_bank_q] : '0;

endmodule
`default_nettype wire
